axis_preamble_inserter: RTL

Transmit-side framing block for the LiFi OFDM link. It prepends a periodic training preamble to every payload frame arriving on an AXI-Stream slave port, and emits the result on an AXI-Stream master port toward the DAC path. The preamble is a REPS-fold repetition of a PERIOD-sample sequence, the delay-correlation structure the receiver synchronizer's metric locks onto. Payload samples pass through unmodified after the preamble.

---
 rtl/lifi_tx_pkg.sv | 27 ++
 rtl/preamble_rom.sv | 14 +
 rtl/axis_preamble_inserter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/lifi_tx_pkg.sv
// Shared LiFi transmit definitions: FSM encoding, default framing constants and the training-preamble table.
// PREAMBLE_GUARD_EN adds the GUARD state to the encoding.
package lifi_tx_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int PERIOD_DEF    = 16;
    localparam int REPS_DEF      = 10;
    localparam int GUARD_LEN_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
`ifdef PREAMBLE_GUARD_EN
        ST_GUARD    = 2'd2,
`endif
        ST_PAYLOAD  = 2'd3
    } state_t;

    // One training period; the receiver synchronizer model uses this same table.
    localparam logic signed [DATA_W_DEF-1:0] PREAMBLE_ROM [PERIOD_DEF] = '{
        32'sh0000_4000, 32'sh0000_2D41, 32'shFFFF_C000, 32'sh0000_16A1,
        32'shFFFF_D2BF, 32'sh0000_3B21, 32'shFFFF_E95F, 32'sh0000_0C7C,
        32'shFFFF_F384, 32'sh0000_22A3, 32'shFFFF_C4DF, 32'sh0000_1E2B,
        32'shFFFF_DD5D, 32'sh0000_353D, 32'shFFFF_CAC3, 32'sh0000_08D3
    };

endpackage

// File: rtl/preamble_rom.sv
// Combinational lookup of one training-preamble sample by phase index.
module preamble_rom
    import lifi_tx_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int PERIOD = PERIOD_DEF
) (
    input  logic [$clog2(PERIOD)-1:0] idx,
    output logic [DATA_W-1:0]         sample
);

    assign sample = DATA_W'(PREAMBLE_ROM[idx]);

endmodule

// File: rtl/axis_preamble_inserter.sv
// Prepends a REPS x PERIOD training preamble to each AXI-Stream payload frame.
// Define PREAMBLE_GUARD_EN to insert GUARD_LEN zero samples between preamble and payload.
//
// state       | meaning
// ------------|-----------------------------------------------------------
// ST_IDLE     | no frame in progress, waiting for s_axis_tvalid
// ST_PREAMBLE | emitting ROM[phase] for REPS repetitions
// ST_GUARD    | emitting zero samples (guard build only)
// ST_PAYLOAD  | passing payload samples through until s_axis_tlast
module axis_preamble_inserter
    import lifi_tx_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int PERIOD    = PERIOD_DEF,
    parameter int REPS      = REPS_DEF,
    parameter int GUARD_LEN = GUARD_LEN_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic              s_axis_tlast,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy
);

    localparam int PH_W  = $clog2(PERIOD);
    localparam int REP_W = $clog2(REPS);

    state_t state, state_nxt;

    logic [PH_W-1:0]   phase;
    logic [REP_W-1:0]  rep_left;
    logic              load;
    logic              pre_last;
    logic              ld_en;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;
    logic [DATA_W-1:0] rom_data;

    assign load     = !m_axis_tvalid || m_axis_tready;
    assign pre_last = (phase == PH_W'(PERIOD - 1)) && (rep_left == '0);

    preamble_rom #(
        .DATA_W (DATA_W),
        .PERIOD (PERIOD)
    ) u_rom (
        .idx    (phase),
        .sample (rom_data)
    );

    // Phase counts up to address the ROM; repetitions count down to a terminal zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase    <= '0;
            rep_left <= '0;
        end else if (state == ST_IDLE) begin
            phase    <= '0;
            rep_left <= REP_W'(REPS - 1);
        end else if (state == ST_PREAMBLE && load) begin
            if (phase == PH_W'(PERIOD - 1)) begin
                phase    <= '0;
                rep_left <= rep_left - REP_W'(1);
            end else begin
                phase <= phase + PH_W'(1);
            end
        end
    end

`ifdef PREAMBLE_GUARD_EN
    localparam int G_W = $clog2(GUARD_LEN + 1);

    logic [G_W-1:0] guard_left;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            guard_left <= '0;
        end else if (state == ST_PREAMBLE && load && pre_last) begin
            guard_left <= G_W'(GUARD_LEN);
        end else if (state == ST_GUARD && load) begin
            guard_left <= guard_left - G_W'(1);
        end
    end
`else
    logic unused_guard_len;
    assign unused_guard_len = (GUARD_LEN != 0);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (s_axis_tvalid) state_nxt = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                if (load && pre_last) begin
`ifdef PREAMBLE_GUARD_EN
                    state_nxt = ST_GUARD;
`else
                    state_nxt = ST_PAYLOAD;
`endif
                end
            end
`ifdef PREAMBLE_GUARD_EN
            ST_GUARD: begin
                if (load && guard_left == G_W'(1)) state_nxt = ST_PAYLOAD;
            end
`endif
            ST_PAYLOAD: begin
                if (s_axis_tvalid && load && s_axis_tlast) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        s_axis_tready = 1'b0;
        busy          = (state != ST_IDLE);
        ld_en         = 1'b0;
        ld_data       = '0;
        ld_last       = 1'b0;
        case (state)
            ST_PREAMBLE: begin
                ld_en   = 1'b1;
                ld_data = rom_data;
            end
`ifdef PREAMBLE_GUARD_EN
            ST_GUARD: begin
                ld_en = 1'b1;
            end
`endif
            ST_PAYLOAD: begin
                s_axis_tready = load;
                ld_en         = s_axis_tvalid;
                ld_data       = s_axis_tdata;
                ld_last       = s_axis_tlast;
            end
            default: ;
        endcase
    end

    // Single output register stage; valid falls only when nothing new is loaded.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (load) begin
            m_axis_tvalid <= ld_en;
            if (ld_en) begin
                m_axis_tdata <= ld_data;
                m_axis_tlast <= ld_last;
            end
        end
    end

endmodule
